// File: rtl/pwm_ramp_ctrl.sv
// Ramp controller for a PWM core. It accepts a period/target/step command and
// moves the compare value one step toward the target at each PWM period boundary.
module pwm_ramp_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_target,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             estop,
    input  logic             pwm_fetch,
    output logic [WIDTH-1:0] pwm_peirod,
    output logic [WIDTH-1:0] pwm_compare,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RAMP  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_period_lat;
    logic [WIDTH-1:0] r_target_lat;
    logic [WIDTH-1:0] r_step_lat;
    logic [WIDTH-1:0] r_pwm_peirod;
    logic [WIDTH-1:0] r_pwm_compare;
    logic             r_done;

    logic [WIDTH-1:0] w_clamped_target;
    logic [WIDTH-1:0] w_dist;
    logic [WIDTH-1:0] w_next_compare;
    logic             w_going_up;
    logic             w_accept;

    assign cfg_ready   = (r_state == S_IDLE) && !estop && !reset;
    assign w_accept    = cfg_valid && cfg_ready;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign pwm_peirod  = r_pwm_peirod;
    assign pwm_compare = r_pwm_compare;

    assign w_clamped_target = (cfg_target > cfg_period) ? cfg_period : cfg_target;

    // Distance is computed before stepping so a move of 'step' can never
    // overshoot the target or wrap below zero.
    always_comb begin
        w_going_up = (r_target_lat >= r_pwm_compare);
        w_dist     = w_going_up ? (r_target_lat - r_pwm_compare)
                                : (r_pwm_compare - r_target_lat);
        if ((r_step_lat == '0) || (w_dist <= r_step_lat)) begin
            w_next_compare = r_target_lat;
        end else if (w_going_up) begin
            w_next_compare = r_pwm_compare + r_step_lat;
        end else begin
            w_next_compare = r_pwm_compare - r_step_lat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_period_lat  <= '0;
            r_target_lat  <= '0;
            r_step_lat    <= '0;
            r_pwm_peirod  <= '0;
            r_pwm_compare <= '0;
            r_done        <= 1'b0;
        end else if (estop) begin
            // Abort drops the command; the period is left untouched on purpose.
            r_state       <= S_IDLE;
            r_pwm_compare <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_period_lat <= cfg_period;
                        r_target_lat <= w_clamped_target;
                        r_step_lat   <= cfg_step;
                        r_state      <= S_ARMED;
                    end
                end
                S_ARMED, S_RAMP: begin
                    if (pwm_fetch) begin
                        if (r_state == S_ARMED) begin
                            r_pwm_peirod <= r_period_lat;
                        end
                        r_pwm_compare <= w_next_compare;
                        if (w_next_compare == r_target_lat) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RAMP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps up/down, clamping, estop abort,
// back-pressure while busy, fetch in the acceptance cycle and reset mid-ramp.
module tb_pwm_ramp_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic [31:0] cfg_target;
    logic [31:0] cfg_step;
    logic        estop;
    logic        pwm_fetch;
    logic [31:0] pwm_peirod;
    logic [31:0] pwm_compare;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_ramp_ctrl #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_target  (cfg_target),
        .cfg_step    (cfg_step),
        .estop       (estop),
        .pwm_fetch   (pwm_fetch),
        .pwm_peirod  (pwm_peirod),
        .pwm_compare (pwm_compare),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fetch_pulse();
        pwm_fetch = 1'b1;
        tick();
        pwm_fetch = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] p, input logic [31:0] t, input logic [31:0] s);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_target = t;
        cfg_step   = s;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_target = '0;
        cfg_step = '0; estop = 1'b0; pwm_fetch = 1'b0;

        // Reset state
        idle(2);
        check("rst_period", pwm_peirod, 0);
        check("rst_compare", pwm_compare, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ready", {31'd0, cfg_ready}, 0);
        reset = 1'b0;
        #1;
        check("idle_ready", {31'd0, cfg_ready}, 1);

        // Ramp up 0 -> 40 in steps of 10, fetch every 100 cycles
        send_cmd(100, 40, 10);
        check("s1_busy_armed", {31'd0, busy}, 1);
        check("s1_ready_armed", {31'd0, cfg_ready}, 0);
        check("s1_period_before", pwm_peirod, 0);
        for (int k = 1; k <= 4; k++) begin
            idle(99);
            check("s1_hold_compare", pwm_compare, 32'(10 * (k - 1)));
            fetch_pulse();
            check("s1_compare", pwm_compare, 32'(10 * k));
            check("s1_period", pwm_peirod, 100);
            check("s1_done", {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
        end
        tick();
        check("s1_done_clear", {31'd0, done}, 0);
        check("s1_busy_after", {31'd0, busy}, 0);

        // Ramp down 40 -> 15 in steps of 10, last step shortened
        send_cmd(100, 15, 10);
        idle(4); fetch_pulse();
        check("s2_c30", pwm_compare, 30);
        check("s2_nodone1", {31'd0, done}, 0);
        idle(4); fetch_pulse();
        check("s2_c20", pwm_compare, 20);
        idle(4); fetch_pulse();
        check("s2_c15", pwm_compare, 15);
        check("s2_done", {31'd0, done}, 1);
        tick();
        check("s2_done_once", {31'd0, done}, 0);

        // Target above period is clamped; step 0 jumps
        send_cmd(100, 150, 0);
        fetch_pulse();
        check("s3_period", pwm_peirod, 100);
        check("s3_compare", pwm_compare, 100);
        check("s3_done", {31'd0, done}, 1);
        check("s3_busy", {31'd0, busy}, 0);

        // Target equal to current compare still waits for one fetch
        send_cmd(120, 100, 5);
        idle(3);
        check("eq_wait_busy", {31'd0, busy}, 1);
        check("eq_wait_period", pwm_peirod, 100);
        fetch_pulse();
        check("eq_period", pwm_peirod, 120);
        check("eq_compare", pwm_compare, 100);
        check("eq_done", {31'd0, done}, 1);

        // estop mid-ramp at compare 20 with a simultaneous fetch
        send_cmd(100, 0, 0);
        fetch_pulse();
        check("s4_prep_zero", pwm_compare, 0);
        send_cmd(100, 40, 10);
        fetch_pulse();
        fetch_pulse();
        check("s4_c20", pwm_compare, 20);
        estop = 1'b1; pwm_fetch = 1'b1;
        tick();
        pwm_fetch = 1'b0;
        check("s4_estop_compare", pwm_compare, 0);
        check("s4_estop_done", {31'd0, done}, 0);
        check("s4_estop_busy", {31'd0, busy}, 0);
        check("s4_estop_ready", {31'd0, cfg_ready}, 0);
        check("s4_estop_period", pwm_peirod, 100);
        send_cmd(70, 50, 0);
        check("s4_estop_no_accept", {31'd0, busy}, 0);
        estop = 1'b0;
        #1;
        check("s4_ready_after", {31'd0, cfg_ready}, 1);
        fetch_pulse();
        check("s4_no_resume", pwm_compare, 0);
        check("s4_no_resume_busy", {31'd0, busy}, 0);

        // cfg_valid held through a ramp is back-pressured until done
        send_cmd(50, 20, 10);
        cfg_valid = 1'b1; cfg_period = 60; cfg_target = 5; cfg_step = 0;
        #1;
        check("s5_ready_armed", {31'd0, cfg_ready}, 0);
        fetch_pulse();
        check("s5_c10", pwm_compare, 10);
        check("s5_ready_ramp", {31'd0, cfg_ready}, 0);
        tick();
        check("s5_busy_hold", {31'd0, busy}, 1);
        fetch_pulse();
        check("s5_c20", pwm_compare, 20);
        check("s5_done", {31'd0, done}, 1);
        check("s5_ready_idle", {31'd0, cfg_ready}, 1);
        tick();
        cfg_valid = 1'b0;
        check("s5_accepted", {31'd0, busy}, 1);
        fetch_pulse();
        check("s5_new_period", pwm_peirod, 60);
        check("s5_new_compare", pwm_compare, 5);
        check("s5_new_done", {31'd0, done}, 1);

        // Fetch in the acceptance cycle is ignored; then reset mid-ramp
        pwm_fetch = 1'b1;
        send_cmd(200, 30, 10);
        pwm_fetch = 1'b0;
        check("s6_ign_compare", pwm_compare, 5);
        check("s6_ign_period", pwm_peirod, 60);
        fetch_pulse();
        check("s6_c15", pwm_compare, 15);
        check("s6_period", pwm_peirod, 200);
        fetch_pulse();
        check("s6_c25", pwm_compare, 25);
        reset = 1'b1; pwm_fetch = 1'b1; cfg_valid = 1'b1; estop = 1'b1;
        tick();
        pwm_fetch = 1'b0; cfg_valid = 1'b0; estop = 1'b0;
        check("s6_rst_period", pwm_peirod, 0);
        check("s6_rst_compare", pwm_compare, 0);
        check("s6_rst_busy", {31'd0, busy}, 0);
        check("s6_rst_done", {31'd0, done}, 0);
        check("s6_rst_ready", {31'd0, cfg_ready}, 0);
        reset = 1'b0;
        #1;
        check("s6_ready_after", {31'd0, cfg_ready}, 1);
        fetch_pulse();
        check("s6_discarded", pwm_compare, 0);
        check("s6_discarded_busy", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
